// File: rtl/control_sequencer_if.sv
// Handshake and control bundle between the instruction sequencer and its datapath.
// The master side is the sequencer; the slave side is the datapath or a bench driving it.
interface control_sequencer_if;
    logic        run;
    logic        mem_ready;
    logic [31:0] ir;
    logic [31:0] enable;
    logic [31:0] busSelect;
    logic        MR_Read;
    logic        pc_inc;
    logic [3:0]  Control_Signals;
    logic        done;
    logic        halted;
    logic [15:0] instr_count;

    modport master (
        input  run, mem_ready, ir,
        output enable, busSelect, MR_Read, pc_inc, Control_Signals, done, halted, instr_count
    );

    modport slave (
        output run, mem_ready, ir,
        input  enable, busSelect, MR_Read, pc_inc, Control_Signals, done, halted, instr_count
    );
endinterface

// File: rtl/control_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer: walks IDLE -> T0..T5 per instruction and
// drives register load enables, bus source select and ALU op as a Moore decode of state.
module control_sequencer (
    input  logic                 clk,
    input  logic                 clr,
    control_sequencer_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        T0   = 3'd1,
        T1   = 3'd2,
        T2   = 3'd3,
        T3   = 3'd4,
        T4   = 3'd5,
        T5   = 3'd6,
        HALT = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        CLS_ALU,
        CLS_NOP,
        CLS_HALT
    } op_class_t;

    typedef struct packed {
        logic [4:0] op;
        logic [3:0] ra;
        logic [3:0] rc;
    } fields_t;

    localparam logic [31:0] EN_MDR  = 32'h0020_0000;
    localparam logic [31:0] EN_IR   = 32'h0080_0000;
    localparam logic [31:0] EN_Z    = 32'h0100_0000;
    localparam logic [31:0] EN_MAR  = 32'h0200_0000;
    localparam logic [31:0] EN_Y    = 32'h0800_0000;

    localparam logic [31:0] SEL_ZLO = 32'd19;
    localparam logic [31:0] SEL_PC  = 32'd20;
    localparam logic [31:0] SEL_MDR = 32'd21;

    function automatic op_class_t classify(input logic [4:0] op);
        if (op == 5'b11111)
            return CLS_HALT;
        if (op[4:2] == 3'b000)
            return CLS_ALU;
        return CLS_NOP;
    endfunction

    function automatic logic [3:0] alu_code(input logic [4:0] op);
        case (op)
            5'd0:    return 4'd1;
            5'd1:    return 4'd2;
            5'd2:    return 4'd3;
            5'd3:    return 4'd4;
            default: return 4'd0;
        endcase
    endfunction

    state_t      state_q, state_d;
    fields_t     fields_q, fields_d;
    logic [15:0] count_q, count_d;

    logic [31:0] enable_c;
    logic [31:0] sel_c;
    logic        mr_read_c;
    logic        pc_inc_c;
    logic [3:0]  alu_c;
    logic        done_c;
    logic        halted_c;

    logic [4:0]  ir_op;
    logic [3:0]  ir_ra;
    logic [3:0]  ir_rb;
    logic [3:0]  ir_rc;
    logic        unused_ir;

    assign ir_op     = bus.ir[31:27];
    assign ir_ra     = bus.ir[26:23];
    assign ir_rb     = bus.ir[22:19];
    assign ir_rc     = bus.ir[18:15];
    assign unused_ir = ^bus.ir[14:0];

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= IDLE;
            fields_q <= '0;
            count_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q  <= state_d;
            fields_q <= fields_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        // NOTE: every output and next-state signal gets a default first, so no path infers a latch.
        state_d   = state_q;
        fields_d  = fields_q;
        count_d   = count_q;
        enable_c  = '0;
        sel_c     = '0;
        mr_read_c = 1'b0;
        pc_inc_c  = 1'b0;
        alu_c     = '0;
        done_c    = 1'b0;
        halted_c  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.run)
                    state_d = T0;
            end
            T0: begin
                sel_c    = SEL_PC;
                enable_c = EN_MAR;
                pc_inc_c = 1'b1;
                state_d  = T1;
            end
            T1: begin
                mr_read_c = 1'b1;
                enable_c  = EN_MDR;
                if (bus.mem_ready)
                    state_d = T2;
            end
            T2: begin
                sel_c    = SEL_MDR;
                enable_c = EN_IR;
                state_d  = T3;
            end
            T3: begin
                // Fields are latched here so T4/T5 decode stays stable if ir moves on.
                fields_d = '{op: ir_op, ra: ir_ra, rc: ir_rc};
                case (classify(ir_op))
                    CLS_ALU: begin
                        sel_c    = {28'd0, ir_rb};
                        enable_c = EN_Y;
                        state_d  = T4;
                    end
                    CLS_HALT: state_d = HALT;
                    default:  state_d = T5;
                endcase
            end
            T4: begin
                sel_c    = {28'd0, fields_q.rc};
                enable_c = EN_Z;
                alu_c    = alu_code(fields_q.op);
                state_d  = T5;
            end
            T5: begin
                if (classify(fields_q.op) == CLS_ALU) begin
                    sel_c    = SEL_ZLO;
                    enable_c = 32'd1 << fields_q.ra;
                end
                done_c  = 1'b1;
                count_d = count_q + 16'd1;
                state_d = bus.run ? T0 : IDLE;
            end
            HALT: begin
                halted_c = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.enable          = enable_c;
    assign bus.busSelect       = sel_c;
    assign bus.MR_Read         = mr_read_c;
    assign bus.pc_inc          = pc_inc_c;
    assign bus.Control_Signals = alu_c;
    assign bus.done            = done_c;
    assign bus.halted          = halted_c;
    assign bus.instr_count     = count_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: per-cycle output vectors checked against
// hand-computed constants for fetch, ALU ops, NOP, memory wait, HALT, reset and wrap.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    int          checks = 0;
    int          passed = 0;
    logic [15:0] exp_count = '0;

    control_sequencer_if bus_if ();

    control_sequencer dut (
        .clk (clk),
        .clr (clr),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    // {enable, busSelect, MR_Read, pc_inc, Control_Signals, done, halted}
    logic [71:0] obs;
    assign obs = {bus_if.enable, bus_if.busSelect, bus_if.MR_Read, bus_if.pc_inc,
                  bus_if.Control_Signals, bus_if.done, bus_if.halted};

    localparam logic [71:0] O_ZERO   = '0;
    localparam logic [71:0] O_T0     = {32'h0200_0000, 32'd20, 1'b0, 1'b1, 4'd0, 2'b00};
    localparam logic [71:0] O_T1     = {32'h0020_0000, 32'd0,  1'b1, 1'b0, 4'd0, 2'b00};
    localparam logic [71:0] O_T2     = {32'h0080_0000, 32'd21, 2'b00, 4'd0, 2'b00};
    localparam logic [71:0] O_NOP_T5 = {32'd0, 32'd0, 2'b00, 4'd0, 2'b10};
    localparam logic [71:0] O_HALT   = {32'd0, 32'd0, 2'b00, 4'd0, 2'b01};

    localparam logic [31:0] IR_NOP  = 32'h2800_0000;
    localparam logic [31:0] IR_HALT = 32'hF800_0000;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus_if.run       = 1'b0;
        bus_if.mem_ready = 1'b0;
        bus_if.ir        = '0;
        #1 clr = 1'b1;
        #2;
        checks++;
        if ({obs, bus_if.instr_count} !== {O_ZERO, 16'h0000})
            $display("FAIL reset_async: outputs=%h count=%h expected all zero", obs, bus_if.instr_count);
        else
            passed++;
        bus_if.run = 1'b1;
        step();
        checks++;
        if (obs !== O_ZERO)
            $display("FAIL reset_held_over_edge: outputs=%h expected=%h", obs, O_ZERO);
        else
            passed++;
        bus_if.run = 1'b0;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic test_idle();
        bus_if.mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({obs, bus_if.instr_count} !== {O_ZERO, exp_count})
                $display("FAIL idle_hold cycle %0d: outputs=%h count=%h expected=%h count=%h",
                         i, obs, bus_if.instr_count, O_ZERO, exp_count);
            else
                passed++;
        end
    endtask

    task automatic test_alu_instr(input string name, input logic [31:0] irv,
                                  input logic [31:0] t3_bus, input logic [31:0] t4_bus,
                                  input logic [3:0] cs, input logic [31:0] t5_en);
        logic [71:0] e [6];
        e[0] = O_T0;
        e[1] = O_T1;
        e[2] = O_T2;
        e[3] = {32'h0800_0000, t3_bus, 2'b00, 4'd0, 2'b00};
        e[4] = {32'h0100_0000, t4_bus, 2'b00, cs, 2'b00};
        e[5] = {t5_en, 32'd19, 2'b00, 4'd0, 2'b10};
        bus_if.ir        = irv;
        bus_if.mem_ready = 1'b1;
        bus_if.run       = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (i == 0)
                bus_if.run = 1'b0;
            checks++;
            if (obs !== e[i])
                $display("FAIL %s T%0d: outputs=%h expected=%h", name, i, obs, e[i]);
            else
                passed++;
        end
        exp_count++;
        step();
        checks++;
        if ({obs, bus_if.instr_count} !== {O_ZERO, exp_count})
            $display("FAIL %s retire: outputs=%h count=%h expected=%h count=%h",
                     name, obs, bus_if.instr_count, O_ZERO, exp_count);
        else
            passed++;
    endtask

    task automatic test_alu_ops();
        // SUB  op=1 ra=4  rb=5  rc=0
        test_alu_instr("sub", 32'h0A28_0000, 32'd5,  32'd0,  4'd2, 32'h0000_0010);
        // ADD  op=0 ra=3  rb=7  rc=9
        test_alu_instr("add", 32'h01BC_8000, 32'd7,  32'd9,  4'd1, 32'h0000_0008);
        // AND  op=2 ra=15 rb=0  rc=1
        test_alu_instr("and", 32'h1780_8000, 32'd0,  32'd1,  4'd3, 32'h0000_8000);
        // OR   op=3 ra=0  rb=15 rc=14
        test_alu_instr("or",  32'h187F_0000, 32'd15, 32'd14, 4'd4, 32'h0000_0001);
    endtask

    task automatic test_mem_wait();
        bus_if.ir        = IR_NOP;
        bus_if.mem_ready = 1'b0;
        bus_if.run       = 1'b1;
        step();
        bus_if.run = 1'b0;
        checks++;
        if (obs !== O_T0)
            $display("FAIL mem_wait T0: outputs=%h expected=%h", obs, O_T0);
        else
            passed++;
        for (int c = 1; c <= 4; c++) begin
            step();
            checks++;
            if (obs !== O_T1)
                $display("FAIL mem_wait T1 cycle %0d: outputs=%h expected=%h", c, obs, O_T1);
            else
                passed++;
            if (c == 4)
                bus_if.mem_ready = 1'b1;
        end
        step();
        checks++;
        if (obs !== O_T2)
            $display("FAIL mem_wait T2_after_ready: outputs=%h expected=%h", obs, O_T2);
        else
            passed++;
        step();
        checks++;
        if (obs !== O_ZERO)
            $display("FAIL nop T3: outputs=%h expected=%h", obs, O_ZERO);
        else
            passed++;
        step();
        checks++;
        if (obs !== O_NOP_T5)
            $display("FAIL nop T5: outputs=%h expected=%h", obs, O_NOP_T5);
        else
            passed++;
        exp_count++;
        step();
        checks++;
        if ({obs, bus_if.instr_count} !== {O_ZERO, exp_count})
            $display("FAIL nop retire: outputs=%h count=%h expected=%h count=%h",
                     obs, bus_if.instr_count, O_ZERO, exp_count);
        else
            passed++;
    endtask

    task automatic test_halt();
        logic [71:0] e [4];
        e[0] = O_T0;
        e[1] = O_T1;
        e[2] = O_T2;
        e[3] = O_ZERO;
        bus_if.ir        = IR_HALT;
        bus_if.mem_ready = 1'b1;
        bus_if.run       = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (obs !== e[i])
                $display("FAIL halt_fetch T%0d: outputs=%h expected=%h", i, obs, e[i]);
            else
                passed++;
        end
        for (int i = 0; i < 12; i++) begin
            step();
            bus_if.mem_ready = i[0];
            checks++;
            if ({obs, bus_if.instr_count} !== {O_HALT, exp_count})
                $display("FAIL halt_hold cycle %0d: outputs=%h count=%h expected=%h count=%h",
                         i, obs, bus_if.instr_count, O_HALT, exp_count);
            else
                passed++;
        end
        #2 clr = 1'b1;
        #1;
        exp_count = '0;
        checks++;
        if ({obs, bus_if.instr_count} !== {O_ZERO, exp_count})
            $display("FAIL halt_clr: outputs=%h count=%h expected all zero", obs, bus_if.instr_count);
        else
            passed++;
        @(negedge clk);
        bus_if.run = 1'b0;
        clr        = 1'b0;
        step();
        checks++;
        if (obs !== O_ZERO)
            $display("FAIL halt_exit_idle: outputs=%h expected=%h", obs, O_ZERO);
        else
            passed++;
    endtask

    task automatic test_back_to_back();
        logic [71:0] e [10];
        for (int k = 0; k < 2; k++) begin
            e[k*5 + 0] = O_T0;
            e[k*5 + 1] = O_T1;
            e[k*5 + 2] = O_T2;
            e[k*5 + 3] = O_ZERO;
            e[k*5 + 4] = O_NOP_T5;
        end
        bus_if.ir        = IR_NOP;
        bus_if.mem_ready = 1'b1;
        bus_if.run       = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (i == 5)
                bus_if.run = 1'b0;
            checks++;
            if (obs !== e[i])
                $display("FAIL back_to_back cycle %0d: outputs=%h expected=%h", i, obs, e[i]);
            else
                passed++;
        end
        exp_count = exp_count + 16'd2;
        step();
        checks++;
        if ({obs, bus_if.instr_count} !== {O_ZERO, exp_count})
            $display("FAIL back_to_back retire: outputs=%h count=%h expected=%h count=%h",
                     obs, bus_if.instr_count, O_ZERO, exp_count);
        else
            passed++;
    endtask

    task automatic test_reset_mid_t4();
        logic [71:0] e [5];
        e[0] = O_T0;
        e[1] = O_T1;
        e[2] = O_T2;
        e[3] = {32'h0800_0000, 32'd7, 2'b00, 4'd0, 2'b00};
        e[4] = {32'h0100_0000, 32'd9, 2'b00, 4'd1, 2'b00};
        bus_if.ir        = 32'h01BC_8000;
        bus_if.mem_ready = 1'b1;
        bus_if.run       = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (obs !== e[i])
                $display("FAIL mid_t4 T%0d: outputs=%h expected=%h", i, obs, e[i]);
            else
                passed++;
        end
        #2 clr = 1'b1;
        #1;
        exp_count = '0;
        checks++;
        if ({obs, bus_if.instr_count} !== {O_ZERO, exp_count})
            $display("FAIL mid_t4_clr: outputs=%h count=%h expected all zero", obs, bus_if.instr_count);
        else
            passed++;
        @(negedge clk);
        bus_if.run = 1'b0;
        clr        = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if ({obs, bus_if.instr_count} !== {O_ZERO, exp_count})
                $display("FAIL mid_t4_no_done cycle %0d: outputs=%h count=%h expected all zero",
                         i, obs, bus_if.instr_count);
            else
                passed++;
        end
    endtask

    task automatic test_wrap();
        logic [71:0] e [10];
        for (int k = 0; k < 2; k++) begin
            e[k*5 + 0] = O_T0;
            e[k*5 + 1] = O_T1;
            e[k*5 + 2] = O_T2;
            e[k*5 + 3] = O_ZERO;
            e[k*5 + 4] = O_NOP_T5;
        end
        bus_if.run = 1'b0;
        force dut.count_q = 16'hFFFE;
        step();
        release dut.count_q;
        bus_if.ir        = IR_NOP;
        bus_if.mem_ready = 1'b1;
        bus_if.run       = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (i == 5) begin
                bus_if.run = 1'b0;
                checks++;
                if (bus_if.instr_count !== 16'hFFFF)
                    $display("FAIL wrap_pre: count=%h expected=%h", bus_if.instr_count, 16'hFFFF);
                else
                    passed++;
            end
            checks++;
            if (obs !== e[i])
                $display("FAIL wrap cycle %0d: outputs=%h expected=%h", i, obs, e[i]);
            else
                passed++;
        end
        step();
        checks++;
        if ({obs, bus_if.instr_count} !== {O_ZERO, 16'h0000})
            $display("FAIL wrap_to_zero: outputs=%h count=%h expected zero", obs, bus_if.instr_count);
        else
            passed++;
    endtask

    initial begin
        test_reset();
        test_idle();
        test_alu_ops();
        test_mem_wait();
        test_halt();
        test_back_to_back();
        test_reset_mid_t4();
        test_wrap();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL have exactly one clock domain: clk; reset clr is asynchronous and active-high.
REQ-002 Port clk  input  1  rising-edge system clock.
REQ-003 Port clr  input  1  asynchronous active-high reset.
REQ-004 Port run  input  1  level; high permits fetch of the next instruction.
REQ-005 Port mem_ready  input  1  memory read data valid on MDataIn this cycle.
REQ-006 Port ir  input  32  current instruction register contents from the datapath; fields are op=ir[31:27], ra=ir[26:23], rb=ir[22:19], rc=ir[18:15].
REQ-007 Port enable  output  32  one-hot-per-bit register load mask:
- bits 0-15 = R0-R15
- 20 = PC, 21 = MDR, 23 = IR, 24 = Z, 25 = MAR, 27 = Y
- other bits are always 0.
REQ-008 Port busSelect  output  32  encoded bus source index:
- 0-15 = R0-R15
- 19 = Zlo, 20 = PC, 21 = MDR
- 0 when idle.
REQ-009 Port MR_Read  output  1  MDR loads from MDataIn instead of the bus.
REQ-010 Port pc_inc  output  1  PC increments this cycle.
REQ-011 Port Control_Signals  output  4  ALU operation: 1 = ADD, 2 = SUB, 3 = AND, 4 = OR, 0 = none.
REQ-012 Port done  output  1  one-cycle pulse on instruction retire.
REQ-013 Port halted  output  1  high while in HALT.
REQ-014 Port instr_count  output  16  retired-instruction counter.

Function
REQ-015 The FSM SHALL have states IDLE, T0, T1, T2, T3, T4, T5 and HALT, with one clock per state except where stated below.
REQ-016 IDLE SHALL go to T0 when run=1 and otherwise remain in IDLE; all outputs are 0 except instr_count.
REQ-017 T0 SHALL drive busSelect=20, enable bit25=1 and pc_inc=1, then go to T1.
REQ-018 T1 SHALL drive MR_Read=1 and enable bit21=1, remain in T1 while mem_ready=0, and go to T2 on the edge where mem_ready=1.
REQ-019 T2 SHALL drive busSelect=21 and enable bit23=1, then go to T3; ir is valid from T3 onward.
REQ-020 Opcode decode in T3 SHALL be:
- op 00000 = ADD, 00001 = SUB, 00010 = AND, 00011 = OR
- op 11111 = HALT
- every other op = NOP.
REQ-021 T3 for an ALU opcode SHALL drive busSelect=rb and enable bit27=1, then go to T4.
REQ-022 T3 for a NOP SHALL go directly to T5 with no T3 outputs asserted.
REQ-023 T3 for HALT SHALL go to HALT.
REQ-024 T4 SHALL drive busSelect=rc, enable bit24=1 and Control_Signals per REQ-011, then go to T5; Control_Signals is 0 in all other states.
REQ-025 T5 for an ALU opcode SHALL drive busSelect=19 and enable bit[ra]=1; for a NOP, bus and enable are 0.
REQ-026 T5 SHALL always assert done=1, increment instr_count, and go to T0 if run=1, else to IDLE.
REQ-027 instr_count SHALL wrap from 16'hFFFF to 0 with no flag.
REQ-028 HALT SHALL hold halted=1 with all other outputs 0, ignore run and mem_ready, and exit only via clr; HALT does not increment instr_count and does not assert done.
REQ-029 Outputs SHALL be a Moore decode of the state (plus registered ir fields); enable SHALL never contain more than the bits listed per state.
REQ-030 A register-field value of 0 SHALL be legal (R0) and receive no special handling.
REQ-031 If run drops mid-instruction, the current instruction SHALL complete through T5 before the FSM returns to IDLE.

Reset
REQ-032 While clr=1, independent of clk, the block SHALL be in state IDLE with every output 0, including instr_count=0, halted=0 and done=0.
REQ-033 When clr deasserts, the first state change SHALL occur on the next rising clk.
REQ-034 clr asserted during any of T0-T5 or HALT SHALL abort the instruction, with no done pulse and no count change.

Verification
REQ-035 SUB: with run=1, mem_ready=1 and ir=32'h0A280000 (op=1, ra=4, rb=5, rc=0), the bench SHALL check:
- T0-T5 occur in 6 clocks
- T3 busSelect=5 and enable=32'h08000000
- T4 busSelect=0, enable=32'h01000000 and Control_Signals=2
- T5 busSelect=19, enable=32'h00000010 and done=1
- instr_count=1.
REQ-036 Memory wait: with mem_ready held low 3 cycles in T1, the bench SHALL check that MR_Read=1 persists 4 cycles and T2 follows exactly one cycle after mem_ready rises.
REQ-037 NOP: with op=00101, the bench SHALL check the sequence T3->T5 with no Y/Z/register enables, done=1 and instr_count incremented.
REQ-038 HALT: with op=11111, the bench SHALL check that halted=1 persists for 10+ cycles with run=1 and that clr returns the block to IDLE with instr_count unchanged until reset clears it to 0.
REQ-039 Reset mid-T4: asserting clr between clock edges SHALL immediately give all outputs 0 and state IDLE, with no done pulse.
REQ-040 Wrap: with instr_count preloaded near 16'hFFFF via 65535 NOPs (or forced), the next retire SHALL give instr_count=0 and done=1.
